ifu: RTL and testbench
======================

// Module: ifu
// PURPOSE
// Instruction fetch unit: holds the architectural PC, fetches the word at PC over a valid/ready memory port,
// and presents it to decode. Sits directly upstream of npc: pc drives npc.curr_pc; npc.next_pc returns and is
// latched once decode accepts the current instruction. One outstanding memory request at most.
// PARAMETERS
// RESET_PC      32'h0000_3000  PC value loaded on reset (word aligned)
// COUNT_WIDTH   32             width of fetch_count retire counter
// PORTS
// clk            in   1   clock, all state updates on rising edge
// reset          in   1   asynchronous, active-high; clears all state immediately
// next_pc        in   32  target from npc, sampled only on decode handshake
// pc             out  32  PC of instruction held for decode (feeds npc.curr_pc)
// imem_req_valid out  1   fetch request valid
// imem_req_ready in   1   memory accepts request this cycle
// imem_addr      out  32  fetch address (= pc while requesting)
// imem_rsp_valid in   1   response word valid
// imem_rsp_data  in   32  response instruction word
// instr_valid    out  1   instr/pc hold a fetched instruction
// instr          out  32  fetched instruction word
// instr_ready    in   1   decode consumes instruction this cycle
// fault          out  1   sticky: misaligned next_pc seen; fetch halted
// fetch_count    out  CW  instructions handed to decode, wraps modulo 2^CW
// BEHAVIOUR
// - Reset (async): pc=RESET_PC, state=S_REQ, instr=0, instr_valid=0, fault=0, fetch_count=0,
//   imem_req_valid=0 while reset high; memory shares reset, so no stale response survives it.
// - S_REQ: imem_req_valid=1, imem_addr=pc. req_valid&req_ready -> S_WAIT. Address stable until accepted.
// - S_WAIT: req_valid=0. rsp_valid -> instr<=rsp_data, instr_valid<=1, -> S_HOLD. Response never arrives in
//   the accept cycle (min latency 1); rsp_valid outside S_WAIT is ignored.
// - S_HOLD: instr_valid=1, instr/pc stable. instr_ready -> fetch_count+=1, instr_valid<=0, and:
//   next_pc[1:0]==0 -> pc<=next_pc, -> S_REQ; else fault<=1, pc unchanged, -> S_FAULT.
// - S_FAULT: absorbing; req_valid=0, instr_valid=0; left only by reset.
// - Throughput: min 3 cycles/instruction (REQ,WAIT,HOLD) with zero-wait memory and decode.
// - instr_ready ignored unless instr_valid; next_pc ignored outside the S_HOLD handshake cycle.
// - pc arithmetic is npc's: wrap 0xFFFF_FFFC->0 arrives as next_pc=0 and is accepted normally.
// - fetch_count wraps all-ones -> 0 without side effects.
// - Reset mid-request or mid-hold: all outputs return to reset values asynchronously; fetch restarts at RESET_PC
//   on first edge after release.
// - No X on outputs after reset; instr holds last value when instr_valid=0.
// STRUCTURE
// - ifu.h: state encodings S_REQ/S_WAIT/S_HOLD/S_FAULT (2-bit), default RESET_PC, alignment mask.
// - Sub-module ifu_pc_reg: pc register with async reset to RESET_PC and load enable; FSM, instr buffer and
//   counter stay in ifu.
// - next_pc always comes from npc; ifu never computes pc+4 itself.
// TESTING
// - Reset release, memory ready, rsp 1 cycle later with 0x2408_0001, decode ready -> imem_addr=0x3000,
//   instr=0x2408_0001 at pc=0x3000; next_pc=0x3004 -> second request addr 0x3004; fetch_count=1.
// - imem_req_ready low 4 cycles -> req_valid held, imem_addr constant 0x3000; no state advance.
// - instr_ready low 5 cycles in S_HOLD -> instr/pc stable, next_pc toggling ignored, fetch_count unchanged.
// - Taken branch: next_pc=0x3010 on handshake -> next imem_addr=0x3010; then next_pc=0x0 accepted (wrap case).
// - Handshake with next_pc=0x3006 -> fault=1, pc stays 0x3000, no further req_valid for 20 cycles until reset.
// - Assert reset during S_WAIT and during S_HOLD -> outputs at reset values same cycle; refetch from 0x3000.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC and alignment helper.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] ALIGN_MASK       = 32'h0000_0003;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr & ALIGN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Architectural PC register: loads on enable, returns to the reset PC asynchronously.
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: fetches the word at pc, holds it for decode, then latches next_pc from npc.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            next_pc,
  output logic [31:0]            pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [31:0]            imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  output logic                   instr_valid,
  output logic [31:0]            instr,
  input  logic                   instr_ready,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] fetch_count,
  output state_t                 dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // valid never drops and its payload never changes until that edge. Responses carry no ready.

  state_t state;
  logic   pc_load;

  // The PC only moves on a decode handshake with an aligned target.
  assign pc_load = (state == S_HOLD) && instr_ready && is_aligned(next_pc);

  ifu_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .reset(reset),
    .load (pc_load),
    .d    (next_pc),
    .q    (pc)
  );

  assign imem_addr = pc;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_REQ;
      imem_req_valid <= 1'b0;
      instr          <= 32'h0;
      instr_valid    <= 1'b0;
      fault          <= 1'b0;
      fetch_count    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          // req_valid comes up one edge after reset release, then stays until accepted.
          if (imem_req_valid && imem_req_ready) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            fetch_count <= fetch_count + COUNT_WIDTH'(1);
            instr_valid <= 1'b0;
            if (is_aligned(next_pc)) begin
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              fault <= 1'b1;
              state <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          imem_req_valid <= 1'b0;
          instr_valid    <= 1'b0;
        end
        default: begin
          state <= S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed and randomized checks of ifu against a transaction-level model of fetch, decode and fault.
module tb_ifu;
  import ifu_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   next_pc = 32'h0;
  logic [31:0]   pc;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [31:0]   imem_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [31:0]   imem_rsp_data = 32'h0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic          instr_ready = 1'b0;
  logic          fault;
  logic [CW-1:0] fetch_count;
  state_t        dbg_state;

  ifu #(
    .RESET_PC   (32'h0000_3000),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .next_pc       (next_pc),
    .pc            (pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .fault         (fault),
    .fetch_count   (fetch_count),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard and reference model
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   model_pc = 32'h0000_3000;
  logic [CW-1:0] model_count = '0;
  logic [31:0]   last_instr = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks (all driving and sampling happens on the falling edge)
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);
    model_pc    = 32'h0000_3000;
    model_count = '0;
    last_instr  = 32'h0;
    exp_q.delete();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic do_req(input int stall);
    for (int i = 0; i < stall; i++) begin
      check("req_stall_valid", 32'(imem_req_valid), 32'd1);
      check("req_stall_addr", imem_addr, model_pc);
      step();
    end
    check("req_valid", 32'(imem_req_valid), 32'd1);
    check("req_addr", imem_addr, model_pc);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("req_drop", 32'(imem_req_valid), 32'd0);
  endtask

  task automatic do_rsp(input logic [31:0] data, input int lat);
    for (int i = 1; i < lat; i++) begin
      check("wait_instr_valid", 32'(instr_valid), 32'd0);
      check("wait_instr_hold", instr, last_instr);
      step();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    exp_q.push_back(data);
  endtask

  task automatic do_dec(input logic [31:0] npc, input int stall);
    logic [31:0] exp_instr;
    if (exp_q.size() == 0) begin
      check("dec_queue_empty", 32'd0, 32'd1);
      return;
    end
    exp_instr = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      next_pc        = $urandom;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", instr, exp_instr);
      check("hold_pc", pc, model_pc);
      check("hold_count", 32'(fetch_count), 32'(model_count));
      step();
    end
    imem_rsp_valid = 1'b0;
    check("dec_valid", 32'(instr_valid), 32'd1);
    check("dec_instr", instr, exp_instr);
    check("dec_pc", pc, model_pc);
    instr_ready = 1'b1;
    next_pc     = npc;
    step();
    instr_ready = 1'b0;
    next_pc     = $urandom;
    model_count = model_count + 1'b1;
    last_instr  = exp_instr;
    check("post_count", 32'(fetch_count), 32'(model_count));
    check("post_instr_valid", 32'(instr_valid), 32'd0);
    check("post_instr_hold", instr, exp_instr);
    if (npc[1:0] == 2'b00) begin
      model_pc = npc;
      check("post_pc", pc, model_pc);
      check("post_req_valid", 32'(imem_req_valid), 32'd1);
      check("post_fault", 32'(fault), 32'd0);
    end else begin
      check("fault_set", 32'(fault), 32'd1);
      check("fault_pc", pc, model_pc);
      check("fault_req_valid", 32'(imem_req_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] npc;
    apply_reset();

    // first fetch, with a 4-cycle memory stall and a 5-cycle decode stall
    do_req(4);
    do_rsp(32'h2408_0001, 1);
    do_dec(32'h0000_3004, 5);
    do_req(0);
    do_rsp($urandom, 2);
    do_dec(32'h0000_3010, 0);
    do_req(0);
    do_rsp($urandom, 1);
    do_dec(32'h0000_0000, 0);
    do_req(1);
    do_rsp($urandom, 3);
    do_dec(32'hFFFF_FFFC, 2);
    do_req(0);

    // reset while waiting for a response
    apply_reset();
    do_req(0);
    apply_reset();
    do_req(0);
    do_rsp(32'hDEAD_BEEF, 1);
    // reset while holding for decode
    apply_reset();
    check("refetch_instr", instr, 32'h0);
    do_req(0);

    // randomized traffic; enough retires to wrap the narrow counter
    for (int n = 0; n < 40; n++) begin
      do_rsp($urandom, int'($urandom_range(1, 3)));
      npc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF) & 32'h3FFF_FFFF, 2'b00};
      do_dec(npc, int'($urandom_range(0, 3)));
      do_req(int'($urandom_range(0, 3)));
    end

    // misaligned target halts fetch until reset
    apply_reset();
    do_req(0);
    do_rsp(32'h1234_5678, 1);
    do_dec(32'h0000_3006, 0);
    for (int i = 0; i < 20; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      instr_ready    = 1'($urandom_range(0, 1));
      next_pc        = $urandom;
      step();
      check("halt_req_valid", 32'(imem_req_valid), 32'd0);
      check("halt_instr_valid", 32'(instr_valid), 32'd0);
      check("halt_fault", 32'(fault), 32'd1);
      check("halt_pc", pc, 32'h0000_3000);
      check("halt_count", 32'(fetch_count), 32'(model_count));
      check("halt_state", 32'(dbg_state), 32'(S_FAULT));
    end
    apply_reset();
    do_req(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
